// File: rtl/decode_inst_buffer.sv
// decode_inst_buffer
//   Instruction buffer between fetch and decode. Fetch groups, which may have
//   sparse lanes, are compacted into a circular queue. Decode sees up to
//   DECODE_WIDTH instructions per cycle. A serial instruction is always
//   presented alone in lane 0.
//
// Ports
//   clk, reset      clock and synchronous active-high reset
//   flush           drops all buffered entries on the next edge
//   in_valid/data/serial   fetch group (lane i at bits [i*DATA_W +: DATA_W])
//   in_ready        room for a whole fetch group (registered count only)
//   out_valid/data/serial  decode group, contiguous from lane 0, data zeroed
//                          on invalid lanes
//   out_ready       decode takes the whole presented group
//   count, empty    occupancy
module decode_inst_buffer #(
  parameter int DEPTH        = 8,
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DATA_W       = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [FETCH_WIDTH-1:0]           in_valid,
  input  logic [FETCH_WIDTH*DATA_W-1:0]    in_data,
  input  logic [FETCH_WIDTH-1:0]           in_serial,
  output logic                             in_ready,
  output logic [DECODE_WIDTH-1:0]          out_valid,
  output logic [DECODE_WIDTH*DATA_W-1:0]   out_data,
  output logic [DECODE_WIDTH-1:0]          out_serial,
  input  logic                             out_ready,
  output logic [$clog2(DEPTH):0]           count,
  output logic                             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FILL_LIMIT = CW'(DEPTH - FETCH_WIDTH);

  // Storage: payload and serial flag per entry. Contents are never cleared;
  // occupancy alone decides what is visible.
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [DEPTH-1:0]  r_mem_serial;

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [PW-1:0]           w_wr_addr [FETCH_WIDTH];
  logic [CW-1:0]           w_n_in;
  logic [PW-1:0]           w_rd_addr [DECODE_WIDTH];
  logic [DECODE_WIDTH-1:0] w_lane_serial;
  logic [DECODE_WIDTH-1:0] w_out_valid;
  logic [CW-1:0]           w_n_out;
  logic                    w_stop;
  logic                    w_push;
  logic                    w_pop;

  // Only the registered count feeds in_ready, so out_ready never reaches it.
  assign in_ready = (r_count <= FILL_LIMIT);
  assign w_push   = in_ready && (|in_valid) && !flush && !reset;
  assign w_pop    = out_ready && w_out_valid[0] && !flush;

  // Compaction: each valid lane lands at tail plus the number of valid lanes
  // below it, so sparse groups fill consecutive entries in lane order.
  always_comb begin
    w_n_in = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_wr_addr[i] = r_tail + w_n_in[PW-1:0];
      w_n_in       = w_n_in + CW'(in_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (w_push && in_valid[i]) begin
        r_mem_data[w_wr_addr[i]]   <= in_data[i*DATA_W +: DATA_W];
        r_mem_serial[w_wr_addr[i]] <= in_serial[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DECODE_WIDTH; gi++) begin : g_out_lane
      assign w_rd_addr[gi]     = r_head + PW'(gi);
      assign w_lane_serial[gi] = r_mem_serial[w_rd_addr[gi]];
      assign out_data[gi*DATA_W +: DATA_W] =
        w_out_valid[gi] ? r_mem_data[w_rd_addr[gi]] : '0;
      assign out_serial[gi] = w_out_valid[gi] & w_lane_serial[gi];
    end
  endgenerate

  // Group formation: walk lanes from 0. A serial entry in lane 0 ends the
  // group after itself; a serial entry in a later lane ends the group just
  // before itself so it leads the next group. Any invalid lane ends the walk,
  // keeping out_valid a contiguous prefix.
  always_comb begin
    w_stop      = 1'b0;
    w_out_valid = '0;
    w_n_out     = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (!w_stop && (CW'(i) < r_count) && !((i != 0) && w_lane_serial[i])) begin
        w_out_valid[i] = 1'b1;
        w_n_out        = w_n_out + CW'(1);
        if (w_lane_serial[i]) begin
          w_stop = 1'b1;
        end
      end else begin
        w_stop = 1'b1;
      end
    end
  end

  assign out_valid = w_out_valid;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + w_n_in[PW-1:0];
      end
      if (w_pop) begin
        r_head <= r_head + w_n_out[PW-1:0];
      end
      r_count <= r_count + (w_push ? w_n_in : '0) - (w_pop ? w_n_out : '0);
    end
  end

  assign count = r_count;
  assign empty = (r_count == '0);

endmodule

// File: tb/tb_decode_inst_buffer.sv
module tb_decode_inst_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [1:0]   in_valid;
  logic [127:0] in_data;
  logic [1:0]   in_serial;
  logic         in_ready;
  logic [1:0]   out_valid;
  logic [127:0] out_data;
  logic [1:0]   out_serial;
  logic         out_ready;
  logic [3:0]   count;
  logic         empty;

  int total = 0;
  int bad   = 0;
  logic [63:0] e;

  decode_inst_buffer #(
    .DEPTH(8), .FETCH_WIDTH(2), .DECODE_WIDTH(2), .DATA_W(64)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_serial(in_serial),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_serial(out_serial),
    .out_ready(out_ready), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] d1, input logic [63:0] d0,
                       input logic [1:0] s);
    in_valid  = v;
    in_data   = {d1, d0};
    in_serial = s;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(2'b00, 64'h0, 64'h0, 2'b00);
    tick(); tick();
    reset = 1'b0;
    #1;
    // Reset state
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_empty", 128'(empty), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_out_serial", 128'(out_serial), 128'd0);

    // Fill: five full groups with decode stalled; the fifth is refused
    for (int j = 0; j < 5; j++) begin
      drive(2'b11, 64'(101 + 2*j), 64'(100 + 2*j), 2'b00);
      tick();
      chk($sformatf("fill_count_%0d", j), 128'(count), 128'((j < 4) ? 2*(j+1) : 8));
      chk($sformatf("fill_in_ready_%0d", j), 128'(in_ready), 128'((j < 3) ? 1 : 0));
    end
    drive(2'b00, 64'h0, 64'h0, 2'b00);
    chk("fill_empty", 128'(empty), 128'd0);
    // Drain: exactly the first four groups in order
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain_valid_%0d", j), 128'(out_valid), 128'd3);
      chk($sformatf("drain_data_%0d", j), out_data, {64'(101 + 2*j), 64'(100 + 2*j)});
      tick();
    end
    chk("drain_count", 128'(count), 128'd0);
    chk("drain_empty", 128'(empty), 128'd1);
    chk("drain_out_valid", 128'(out_valid), 128'd0);

    // Sparse compaction
    out_ready = 1'b0;
    drive(2'b10, 64'hB, 64'hDEAD, 2'b00);
    tick();
    chk("sparse_count1", 128'(count), 128'd1);
    chk("sparse_valid1", 128'(out_valid), 128'd1);
    chk("sparse_data1", out_data, {64'h0, 64'hB});
    drive(2'b01, 64'hBEEF, 64'hC, 2'b00);
    tick();
    drive(2'b00, 64'h0, 64'h0, 2'b00);
    chk("sparse_count2", 128'(count), 128'd2);
    chk("sparse_valid2", 128'(out_valid), 128'd3);
    chk("sparse_data2", out_data, {64'hC, 64'hB});
    out_ready = 1'b1;
    tick();
    chk("sparse_drained", 128'(count), 128'd0);

    // Serialization: {A, S} then {C, D}
    out_ready = 1'b0;
    drive(2'b11, 64'h5, 64'hA, 2'b10);
    tick();
    drive(2'b11, 64'hD, 64'hC, 2'b00);
    tick();
    drive(2'b00, 64'h0, 64'h0, 2'b00);
    chk("ser_count", 128'(count), 128'd4);
    out_ready = 1'b1;
    chk("ser_g1_valid", 128'(out_valid), 128'd1);
    chk("ser_g1_data", out_data, {64'h0, 64'hA});
    chk("ser_g1_serial", 128'(out_serial), 128'd0);
    tick();
    chk("ser_g2_valid", 128'(out_valid), 128'd1);
    chk("ser_g2_data", out_data, {64'h0, 64'h5});
    chk("ser_g2_serial", 128'(out_serial), 128'd1);
    tick();
    chk("ser_g3_valid", 128'(out_valid), 128'd3);
    chk("ser_g3_data", out_data, {64'hD, 64'hC});
    chk("ser_g3_serial", 128'(out_serial), 128'd0);
    tick();
    chk("ser_count_end", 128'(count), 128'd0);

    // Wrap-around streaming: push 2 / pop 2 per cycle, values 0..39
    e = 64'd0;
    out_ready = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if (c < 20) drive(2'b11, 64'(2*c + 1), 64'(2*c), 2'b00);
      else        drive(2'b00, 64'h0, 64'h0, 2'b00);
      if (c > 0) begin
        chk($sformatf("wrap_valid_%0d", c), 128'(out_valid), 128'd3);
        chk($sformatf("wrap_data_%0d", c), out_data, {e + 64'd1, e});
        e = e + 64'd2;
      end
      tick();
      chk($sformatf("wrap_count_%0d", c), 128'(count), 128'((c < 20) ? 2 : 0));
    end
    chk("wrap_total", 128'(e), 128'd40);

    // Flush mid-stream with count = 5
    out_ready = 1'b0;
    drive(2'b11, 64'h71, 64'h70, 2'b00); tick();
    drive(2'b11, 64'h73, 64'h72, 2'b00); tick();
    drive(2'b01, 64'h0, 64'h74, 2'b00);  tick();
    chk("flush_pre_count", 128'(count), 128'd5);
    flush = 1'b1; out_ready = 1'b1;
    drive(2'b11, 64'h91, 64'h90, 2'b00);
    tick();
    flush = 1'b0;
    drive(2'b00, 64'h0, 64'h0, 2'b00);
    chk("flush_count", 128'(count), 128'd0);
    chk("flush_out_valid", 128'(out_valid), 128'd0);
    chk("flush_in_ready", 128'(in_ready), 128'd1);
    chk("flush_empty", 128'(empty), 128'd1);
    chk("flush_out_data", out_data, 128'd0);
    tick();
    chk("flush_still_empty", 128'(out_valid), 128'd0);
    out_ready = 1'b0;
    drive(2'b10, 64'hF1, 64'h0, 2'b00);
    tick();
    drive(2'b00, 64'h0, 64'h0, 2'b00);
    chk("post_flush_valid", 128'(out_valid), 128'd1);
    chk("post_flush_data", out_data, {64'h0, 64'hF1});
    chk("post_flush_count", 128'(count), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
